// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Parallel-to-serial pattern transmitter. Words arrive over a valid/ready
//   handshake into a one-word holding register and are shifted out LSB-first.
//   Each frame is followed by a one-cycle frame_done strobe and an optional
//   idle gap. Every output is driven straight from a flop.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   load_data    frame word, bit 0 transmitted first
//   load_valid   producer offers load_data
//   load_ready   holding register empty (word taken on valid & ready)
//   serial_out   serial bit stream
//   bit_valid    serial_out carries a frame bit
//   frame_start  pulse coincident with bit 0
//   frame_done   pulse in the cycle after the last bit
//   busy         transmitter active or a word is waiting
//   frames_sent  completed-frame count, wraps modulo 2^CNT_W
module serial_pattern_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 10,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  serial_out,
  output logic                  bit_valid,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      frames_sent
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  load_ready_q, load_ready_d;
  logic                  serial_q, serial_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      frames_q, frames_d;
  logic                  accept;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    serial_d      = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frames_d      = frames_q;

    // Accept only into an empty holding register; the IDLE drain below only
    // fires when it is full, so the two never touch hold_full in one cycle.
    accept = load_valid && !hold_full_q;
    if (accept) begin
      hold_d      = load_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          // Bit 0 goes straight to the output flop, so the shift register
          // keeps only the bits still to be sent.
          state_d       = SHIFT;
          shreg_d       = hold_q >> 1;
          serial_d      = hold_q[0];
          bit_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          bit_cnt_d     = '0;
          hold_full_d   = 1'b0;
        end
      end
      SHIFT: begin
        // bit_cnt_q is the index of the bit currently on serial_out.
        if (bit_cnt_q == LAST_BIT) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          frames_d     = frames_q + 1'b1;
        end else begin
          serial_d    = shreg_q[0];
          bit_valid_d = 1'b1;
          shreg_d     = shreg_q >> 1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    load_ready_d = ~hold_full_d;
    busy_d       = (state_d != IDLE) || hold_full_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_full_q   <= 1'b0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      load_ready_q  <= 1'b1;
      serial_q      <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      frames_q      <= '0;
    end else begin
      state_q       <= state_d;
      hold_full_q   <= hold_full_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      load_ready_q  <= load_ready_d;
      serial_q      <= serial_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      frames_q      <= frames_d;
    end
  end

  // Holding data needs no reset: hold_full_q alone says whether it is live.
  always_ff @(posedge clock) begin
    hold_q <= hold_d;
  end

  assign load_ready  = load_ready_q;
  assign serial_out  = serial_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] load_data = '0;
  logic          lv_a = 1'b0;
  logic          lv_b = 1'b0;

  logic        lr_a, so_a, bv_a, fs_a, fd_a, busy_a;
  logic [15:0] cnt_a;
  logic        lr_b, so_b, bv_b, fs_b, fd_b, busy_b;
  logic [1:0]  cnt_b;

  serial_pattern_tx #(.DATA_WIDTH(DW), .GAP_CYCLES(10), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .load_data(load_data), .load_valid(lv_a),
    .load_ready(lr_a), .serial_out(so_a), .bit_valid(bv_a), .frame_start(fs_a),
    .frame_done(fd_a), .busy(busy_a), .frames_sent(cnt_a)
  );

  serial_pattern_tx #(.DATA_WIDTH(DW), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .load_data(load_data), .load_valid(lv_b),
    .load_ready(lr_b), .serial_out(so_b), .bit_valid(bv_b), .frame_start(fs_b),
    .frame_done(fd_b), .busy(busy_b), .frames_sent(cnt_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observation port of the instance under test.
  bit          sel_b = 1'b0;
  logic        o_lr, o_so, o_bv, o_fs, o_fd, o_busy;
  logic [15:0] o_cnt;
  always_comb begin
    o_lr   = sel_b ? lr_b   : lr_a;
    o_so   = sel_b ? so_b   : so_a;
    o_bv   = sel_b ? bv_b   : bv_a;
    o_fs   = sel_b ? fs_b   : fs_a;
    o_fd   = sel_b ? fd_b   : fd_a;
    o_busy = sel_b ? busy_b : busy_a;
    o_cnt  = sel_b ? {14'd0, cnt_b} : cnt_a;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  int          starts_q[$];
  int          dones_q[$];
  int          acc_q[$];
  int          fm[2];
  int          stalls;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string who);
    check({who, "_load_ready"}, {31'd0, o_lr}, 1);
    check({who, "_serial_out"}, {31'd0, o_so}, 0);
    check({who, "_bit_valid"}, {31'd0, o_bv}, 0);
    check({who, "_frame_start"}, {31'd0, o_fs}, 0);
    check({who, "_frame_done"}, {31'd0, o_fd}, 0);
    check({who, "_busy"}, {31'd0, o_busy}, 0);
    check({who, "_frames_sent"}, {16'd0, o_cnt}, 0);
  endtask

  // Streams src_q through the selected instance and checks every frame
  // against the words seen accepted, plus frame timing rules.
  task automatic run_stream(input bit rnd, input int max_cyc);
    int          gap = sel_b ? 0 : 10;
    logic [31:0] mask = sel_b ? 32'h3 : 32'hFFFF;
    logic [31:0] asm_w = '0;
    int          nbits = 0;
    int          idle = 0;
    int          t0 = cyc;
    bit          acc_prev = 1'b0;
    bit          lv = 1'b0;
    int          sel = sel_b ? 1 : 0;
    starts_q.delete(); dones_q.delete(); acc_q.delete();
    stalls = 0;
    forever begin
      @(negedge clock);
      if (cyc - t0 > max_cyc) begin
        check("stream_timeout", 1, 0);
        break;
      end
      if (acc_prev) check("ready_low_after_accept", {31'd0, o_lr}, 0);
      if (o_fs) begin
        check("start_at_bit0", 32'(nbits), 0);
        starts_q.push_back(cyc);
      end
      if (o_bv) begin
        check("busy_during_frame", {31'd0, o_busy}, 1);
        if (nbits < DW) asm_w[nbits] = o_so;
        nbits++;
      end else if (o_so !== 1'b0) begin
        check("line_low_when_idle", {31'd0, o_so}, 0);
      end
      if (o_fd) begin
        check("bits_per_frame", 32'(nbits), DW);
        if (starts_q.size() > 0) check("done_after_start", 32'(cyc - starts_q[$]), DW);
        if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
        else check("frame_word", asm_w, exp_q.pop_front());
        fm[sel]++;
        check("frames_sent", {16'd0, o_cnt}, 32'(fm[sel]) & mask);
        dones_q.push_back(cyc);
        nbits = 0;
        asm_w = '0;
      end
      // producer: once valid is raised the word is held until taken
      acc_prev = 1'b0;
      if (!lv && src_q.size() > 0 && (!rnd || $urandom_range(0, 2) == 0)) lv = 1'b1;
      if (lv) load_data = src_q[0];
      if (sel_b) lv_b = lv; else lv_a = lv;
      if (lv && o_lr) begin
        acc_prev = 1'b1;
        exp_q.push_back(src_q.pop_front());
        acc_q.push_back(cyc + 1);
        lv = 1'b0;
      end else if (lv) begin
        stalls++;
      end
      if (src_q.size() == 0 && exp_q.size() == 0 && nbits == 0 && !lv) idle++;
      else idle = 0;
      if (idle >= gap + 2) begin
        check("busy_at_rest", {31'd0, o_busy}, 0);
        check("ready_at_rest", {31'd0, o_lr}, 1);
        break;
      end
    end
    lv_a = 1'b0;
    lv_b = 1'b0;
  endtask

  initial begin
    int bv_seen;
    int fd_seen;
    logic [31:0] w1;
    fm[0] = 0;
    fm[1] = 0;

    // reset state
    repeat (3) @(negedge clock);
    sel_b = 1'b0; #0 check_reset_values("rst_a");
    sel_b = 1'b1; #0 check_reset_values("rst_b");
    reset = 1'b0;
    sel_b = 1'b0;

    // single frame
    src_q.push_back(32'h0000_BFAF);
    run_stream(1'b0, 2000);
    check("single_start_latency", 32'(starts_q[0] - acc_q[0]), 1);
    check("single_count", {16'd0, o_cnt}, 1);

    // back-to-back
    src_q.push_back(32'hA5A5_0001);
    src_q.push_back(32'h0000_FFFF);
    run_stream(1'b0, 2000);
    check("b2b_second_accept", 32'(acc_q[1] - starts_q[0]), 1);
    check("b2b_period", 32'(starts_q[1] - starts_q[0]), 44);
    check("b2b_count", {16'd0, o_cnt}, 3);

    // backpressure: third word waits behind a full holding register
    src_q.push_back($urandom);
    src_q.push_back($urandom);
    src_q.push_back($urandom);
    run_stream(1'b0, 3000);
    check("backpressure_seen", 32'(stalls > 0), 1);
    check("bp_count", {16'd0, o_cnt}, 6);

    // random words with random producer idle time
    for (int i = 0; i < 6; i++) src_q.push_back($urandom);
    run_stream(1'b1, 4000);
    check("rand_count", {16'd0, o_cnt}, 12);

    // zero gap and 2-bit counter wrap
    sel_b = 1'b1;
    for (int i = 0; i < 5; i++) src_q.push_back($urandom);
    run_stream(1'b0, 3000);
    for (int i = 1; i < 5; i++)
      check("gap0_done_to_start", 32'(starts_q[i] - dones_q[i-1]), 2);
    check("wrap_final_count", {16'd0, o_cnt}, 1);

    // reset at bit 10 of a frame with a second word held
    sel_b = 1'b0;
    w1 = $urandom;
    @(negedge clock);
    load_data = w1; lv_a = 1'b1;
    @(negedge clock);
    lv_a = 1'b0;
    @(negedge clock);
    check("rst_frame_started", {31'd0, o_fs}, 1);
    load_data = $urandom; lv_a = 1'b1;
    @(negedge clock);
    lv_a = 1'b0;
    repeat (9) @(negedge clock);
    check("rst_bit10", {31'd0, o_so}, {31'd0, w1[10]});
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("midrst");
    reset = 1'b0;
    fm[0] = 0;
    fm[1] = 0;
    bv_seen = 0;
    fd_seen = 0;
    repeat (60) begin
      @(negedge clock);
      if (o_bv) bv_seen++;
      if (o_fd) fd_seen++;
    end
    check("rst_no_bits", 32'(bv_seen), 0);
    check("rst_no_done", 32'(fd_seen), 0);
    check("rst_count_zero", {16'd0, o_cnt}, 0);
    src_q.push_back($urandom);
    run_stream(1'b0, 2000);
    check("post_rst_count", {16'd0, o_cnt}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
